ins_classifier_pipe: RTL and testbench
======================================

// Module: ins_classifier_pipe
// PURPOSE
//   Registered, flow-controlled instruction classifier for the decode front end.
//   Buffers instructions in a 2-entry FIFO with a valid/ready handshake.
//   Tags each instruction R/I/J1/J2, or illegal for an unknown opcode; no output is ever left floating.
//   Keeps per-class saturating retire counters for performance monitoring.
// PARAMETERS
//   INS_W   32  instruction width
//   OPC_LSB 27  bit index of the opcode LSB; the opcode is in_ins[OPC_LSB+4:OPC_LSB]
//   CNT_W   16  width of each class counter
// PORTS
//   clock      in   1      rising-edge clock
//   reset_n    in   1      asynchronous, active-low reset
//   flush      in   1      synchronous; discards all buffered entries
//   in_valid   in   1      upstream has an instruction
//   in_ready   out  1      block can accept; equals (occupancy < 2) && !flush
//   in_ins     in   INS_W  instruction word
//   out_valid  out  1      head entry is valid
//   out_ready  in   1      downstream accepts the head entry
//   out_ins    out  INS_W  head instruction word
//   out_type   out  3      000 R, 001 I, 010 J1, 011 J2, 100 illegal
//   cnt_sel    in   3      counter select; same encoding as out_type; 101..111 read 0
//   cnt_clear  in   1      synchronous clear of all counters
//   cnt_value  out  CNT_W  combinational read of the selected counter
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     occupancy=0; out_valid=0; out_ins=0; out_type=000; all counters=0.
//   Classification, on the 5-bit opcode op, computed at push and stored with the entry:
//     R  : op==00000
//     I  : op in {00101,00111,01000,00010,00110,10001}
//     J1 : op in {00001,00011,10110,10101}
//     J2 : op==00100
//     all other opcodes -> 100 illegal
//   Handshake:
//     push = in_valid && in_ready; pop = out_valid && out_ready.
//     Data stays stable at the head while out_valid && !out_ready.
//   Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. No combinational in->out path.
//   Occupancy transitions:
//     0 -> 1 on push.
//     1 -> 1 on push+pop; the new entry becomes the head next cycle.
//     1 -> 2 on push only.
//     2 -> 1 on pop; no push is possible at 2 because in_ready=0.
//     1 -> 0 on pop only.
//   FIFO order: strict in-order. The second entry moves to the head on pop.
//   Flush: next cycle occupancy=0 and out_valid=0.
//     in_ready=0 during the flush cycle, so that cycle's input is dropped.
//     A pop in the flush cycle still counts if out_ready=1.
//     Counters are not affected by flush.
//   Counters: five CNT_W counters, one per class.
//     On pop, the counter for the head's out_type increments by 1.
//     Counters saturate at all-ones (no wrap).
//     cnt_clear has priority: in a clear+pop cycle, all counters become 0 and the pop is not counted.
//   Illegal entries flow through like any other class; the block never stalls on them.
// TESTING
//   1. Reset with in_valid=1 -> out_valid=0, in_ready=1, out_type=000; cnt_value=0 for every cnt_sel.
//   2. Push 0x28000000 (op 00101) into an empty FIFO, out_ready=1 -> next cycle out_valid=1, out_type=001;
//      one cycle after the pop, cnt_sel=001 reads 1.
//   3. out_ready=0; push 0x08000000 (op 00001), then 0x20000000 (op 00100) -> in_ready=0 at occupancy 2;
//      then out_ready=1 -> out_type 010, then 011, in order.
//   4. Push 0xF8000000 (op 11111) -> out_type=100; after the pop, cnt_sel=100 reads 1.
//   5. Occupancy 2 plus flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1;
//      the dropped input never appears and counters are unchanged.
//   6. CNT_W=4; pop 17 R-type words (0x00000000) -> cnt_sel=000 reads 15.
//      A cnt_clear coincident with a pop -> reads 0.

Source files
------------

// File: rtl/ins_classifier_pipe.sv
// rtl/ins_classifier_pipe.sv - flow-controlled instruction classifier with 2-entry FIFO and class counters
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   flush                 discard all buffered entries (input dropped that cycle)
//   in_valid/in_ready     upstream handshake, in_ins instruction word
//   out_valid/out_ready   downstream handshake, out_ins/out_type head entry
//   cnt_sel/cnt_clear     counter select and synchronous clear
//   cnt_value             combinational read of the selected class counter

module ins_classifier_pipe #(
  parameter int INS_W   = 32,
  parameter int OPC_LSB = 27,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [2:0]       out_type,
  input  logic [2:0]       cnt_sel,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_value
);

  localparam logic [2:0] T_R   = 3'b000;
  localparam logic [2:0] T_I   = 3'b001;
  localparam logic [2:0] T_J1  = 3'b010;
  localparam logic [2:0] T_J2  = 3'b011;
  localparam logic [2:0] T_ILL = 3'b100;

  // Slot 0 is always the head; slot 1 only holds data at occupancy 2.
  logic [1:0]       occ;
  logic [INS_W-1:0] ins0, ins1;
  logic [2:0]       typ0, typ1;

  logic [4:0] op;
  logic [2:0] in_type;
  logic       push, pop;

  logic [CNT_W-1:0] cnt [5];

  assign op = in_ins[OPC_LSB+4:OPC_LSB];

  always_comb begin
    in_type = T_ILL;
    case (op)
      5'b00000:                                              in_type = T_R;
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110, 5'b10001: in_type = T_I;
      5'b00001, 5'b00011, 5'b10110, 5'b10101:                in_type = T_J1;
      5'b00100:                                              in_type = T_J2;
      default:                                               in_type = T_ILL;
    endcase
  end

  assign in_ready  = (occ != 2'd2) && !flush;
  assign out_valid = (occ != 2'd0);
  assign out_ins   = ins0;
  assign out_type  = typ0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ  <= 2'd0;
      ins0 <= '0;
      ins1 <= '0;
      typ0 <= T_R;
      typ1 <= T_R;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            ins0 <= in_ins;
            typ0 <= in_type;
          end else begin
            ins1 <= in_ins;
            typ1 <= in_type;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          // At occupancy 1 this copies a stale slot, but out_valid drops so it is never consumed.
          ins0 <= ins1;
          typ0 <= typ1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Only reachable at occupancy 1: the new entry replaces the departing head.
          ins0 <= in_ins;
          typ0 <= in_type;
        end
        default: ;
      endcase
    end
  end

  // Clear wins over a coincident pop; a pop during flush still counts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else if (cnt_clear) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (pop && (typ0 == 3'(i)) && (cnt[i] != {CNT_W{1'b1}})) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < 5; i++) begin
      if (cnt_sel == 3'(i)) cnt_value = cnt[i];
    end
  end

endmodule

// File: tb/tb_ins_classifier_pipe.sv
// tb/tb_ins_classifier_pipe.sv - directed self-checking bench for ins_classifier_pipe

module tb_ins_classifier_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ins = '0;
  logic        out_ready = 1'b0;
  logic [2:0]  cnt_sel = 3'd0;
  logic        cnt_clear = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_ins;
  logic [2:0]  out_type;
  logic [15:0] cnt_value;

  logic        in_ready4, out_valid4;
  logic [31:0] out_ins4;
  logic [2:0]  out_type4;
  logic [3:0]  cnt_value4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ins_classifier_pipe dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_type(out_type),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value)
  );

  ins_classifier_pipe #(.CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_ins(in_ins),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ins(out_ins4), .out_type(out_type4),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1. reset with in_valid asserted
    in_valid = 1'b1;
    in_ins   = 32'h2800_0000;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_type", 64'(out_type), 64'd0);
    chk("rst_out_ins", 64'(out_ins), 64'd0);
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      #1;
      chk("rst_cnt", 64'(cnt_value), 64'd0);
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk("rst_still_empty", 64'(out_valid), 64'd0);

    // 2. single I-type push and pop
    in_valid  = 1'b1;
    in_ins    = 32'h2800_0000;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("i_out_valid", 64'(out_valid), 64'd1);
    chk("i_out_type", 64'(out_type), 64'd1);
    chk("i_out_ins", 64'(out_ins), 64'h2800_0000);
    tick();
    cnt_sel = 3'd1;
    #1;
    chk("i_popped", 64'(out_valid), 64'd0);
    chk("i_cnt", 64'(cnt_value), 64'd1);
    chk("i_cnt4", 64'(cnt_value4), 64'd1);

    // 3. fill to two with out_ready low, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins    = 32'h0800_0000;
    tick();
    in_ins = 32'h2000_0000;
    #1;
    chk("occ1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_type", 64'(out_type), 64'd2);
    tick();
    chk("stall_head_ins", 64'(out_ins), 64'h0800_0000);
    out_ready = 1'b1;
    tick();
    chk("second_type", 64'(out_type), 64'd3);
    chk("second_ins", 64'(out_ins), 64'h2000_0000);
    chk("second_valid", 64'(out_valid), 64'd1);
    tick();
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_ready", 64'(in_ready), 64'd1);
    cnt_sel = 3'd2;
    #1;
    chk("j1_cnt", 64'(cnt_value), 64'd1);
    cnt_sel = 3'd3;
    #1;
    chk("j2_cnt", 64'(cnt_value), 64'd1);

    // 4. illegal opcode
    in_valid = 1'b1;
    in_ins   = 32'hF800_0000;
    tick();
    in_valid = 1'b0;
    #1;
    chk("ill_type", 64'(out_type), 64'd4);
    tick();
    cnt_sel = 3'd4;
    #1;
    chk("ill_cnt", 64'(cnt_value), 64'd1);
    chk("ill_valid", 64'(out_valid), 64'd0);

    // 5. flush at occupancy 2 with a coincident input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins    = 32'h1000_0000;
    tick();
    in_ins = 32'h3000_0000;
    tick();
    flush  = 1'b1;
    in_ins = 32'h0800_0000;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready_after", 64'(in_ready), 64'd1);
    tick();
    tick();
    chk("flush_no_ghost", 64'(out_valid), 64'd0);
    cnt_sel = 3'd1;
    #1;
    chk("flush_cnt_i", 64'(cnt_value), 64'd1);
    cnt_sel = 3'd2;
    #1;
    chk("flush_cnt_j1", 64'(cnt_value), 64'd1);

    // pop in the flush cycle still counts
    in_valid = 1'b1;
    in_ins   = 32'h0000_0000;
    tick();
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    cnt_sel   = 3'd0;
    #1;
    chk("flush_pop_valid", 64'(out_valid), 64'd0);
    chk("flush_pop_cnt", 64'(cnt_value), 64'd1);

    // 6. saturation and clear priority
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst2_cnt", 64'(cnt_value), 64'd0);
    in_valid  = 1'b1;
    in_ins    = 32'h0000_0000;
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("sat_cnt4", 64'(cnt_value4), 64'd15);
    chk("nosat_cnt16", 64'(cnt_value), 64'd17);
    chk("sat_head_valid", 64'(out_valid), 64'd1);
    cnt_clear = 1'b1;
    out_ready = 1'b1;
    tick();
    cnt_clear = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("clr_pop_valid", 64'(out_valid), 64'd0);
    chk("clr_cnt4", 64'(cnt_value4), 64'd0);
    chk("clr_cnt16", 64'(cnt_value), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
